// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS-subset controller: opcodes,
// 4-bit state encoding, ALU operand/operation codes and the control word.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [3:0] S_INIT     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_WB_MEM   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_EXEC_R   = 4'd7;
  localparam logic [3:0] S_WB_R     = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_EXEC_LUI = 4'd10;
  localparam logic [3:0] S_WB_LUI   = 4'd11;
  localparam logic [3:0] S_ERROR    = 4'd12;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LUI   = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       iord;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctr;
    logic       instr_done;
  } ctrl_t;

  // States that stall on the memory ready handshake.
  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles; expired_o flags the stalled cycle
// on which the count would reach TIMEOUT_CYCLES (never with clear_i high).
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TW             = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                  cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (TIMEOUT_CYCLES != 0) && inc_i && !clear_i &&
                     (cnt_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multi_cycle_control.sv
// Control FSM for the shared multi-cycle MIPS-subset datapath: sequences
// fetch/decode/execute/memory/writeback and flags illegal ops and memory stalls.
module multi_cycle_control
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TW             = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCSource,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUctr,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  logic [3:0] state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d, timeout_q, timeout_d;
  logic       waiting, expired;
  ctrl_t      c;

  assign waiting = is_wait_state(state_q);

  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TW(TW)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (!waiting || mem_ready),
    .inc_i     (waiting && !mem_ready),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    c         = '0;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_ctr   = ALU_ADD;
        if (mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_d    = S_DECODE;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = S_ERROR;
        end
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_ctr   = ALU_ADD;
        op_d        = op;
        case (op)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_LUI:       state_d = S_EXEC_LUI;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_ERROR;
          end
        endcase
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_ctr   = ALU_ADD;
        state_d     = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
        else if (expired) begin
          timeout_d = 1'b1;
          state_d   = S_ERROR;
        end
      end
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      // The write request is held until memory accepts it.
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        if (mem_ready) begin
          c.instr_done = 1'b1;
          state_d      = S_FETCH;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = S_ERROR;
        end
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_ctr   = ALU_FUNCT;
        state_d     = S_WB_R;
      end
      S_WB_R: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RT;
        c.alu_ctr       = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
        c.instr_done    = 1'b1;
        state_d         = S_FETCH;
      end
      S_EXEC_LUI: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_ctr   = ALU_LUI;
        state_d     = S_WB_LUI;
      end
      S_WB_LUI: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_INIT;
      op_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign PCWrite     = c.pc_write;
  assign PCWriteCond = c.pc_write_cond;
  assign PCSource    = c.pc_source;
  assign IorD        = c.iord;
  assign IRWrite     = c.ir_write;
  assign MemRead     = c.mem_read;
  assign MemWrite    = c.mem_write;
  assign MemtoReg    = c.mem_to_reg;
  assign RegDst      = c.reg_dst;
  assign RegWrite    = c.reg_write;
  assign ALUSrcA     = c.alu_src_a;
  assign ALUSrcB     = c.alu_src_b;
  assign ALUctr      = c.alu_ctr;
  assign instr_done  = c.instr_done;
  assign state       = state_q;
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: directed sequences plus random op/mem_ready
// traffic, checked each cycle against a phase-queue instruction model.
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, PCSource, IorD, IRWrite, MemRead, MemWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op, mem_timeout;
  logic [1:0] ALUSrcB, ALUctr;
  logic [3:0] state;

  multi_cycle_control dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUctr(ALUctr), .state(state),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  logic [15:0] obs_ctrl;
  assign obs_ctrl = {PCWrite, PCWriteCond, PCSource, IorD, IRWrite, MemRead, MemWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUctr, instr_done};

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: the remaining phases of the current instruction sit in a queue.
  typedef enum int {P_INIT, P_FETCH, P_DEC, P_ADDR, P_RD, P_WBM, P_WR,
                    P_EXR, P_WBR, P_BR, P_EXL, P_WBL, P_ERR} ph_t;
  ph_t q[$];
  int  waits;
  bit  m_ill, m_to;

  function automatic logic [15:0] exp_ctrl(input ph_t p, input logic rdy);
    logic pcw, pcwc, pcs, iord, irw, mr, mw, m2r, rd, rw, sa, done;
    logic [1:0] sb, ac;
    {pcw, pcwc, pcs, iord, irw, mr, mw, m2r, rd, rw, sa, done} = '0;
    sb = 2'b00; ac = 2'b00;
    case (p)
      P_FETCH: begin mr = 1; sb = 2'b01; if (rdy) begin irw = 1; pcw = 1; end end
      P_DEC:   sb = 2'b11;
      P_ADDR:  begin sa = 1; sb = 2'b10; end
      P_RD:    begin mr = 1; iord = 1; end
      P_WBM:   begin rw = 1; m2r = 1; done = 1; end
      P_WR:    begin mw = 1; iord = 1; done = rdy; end
      P_EXR:   begin sa = 1; ac = 2'b10; end
      P_WBR:   begin rw = 1; rd = 1; done = 1; end
      P_BR:    begin sa = 1; ac = 2'b01; pcwc = 1; pcs = 1; done = 1; end
      P_EXL:   begin sa = 1; sb = 2'b10; ac = 2'b11; end
      P_WBL:   begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pcwc, pcs, iord, irw, mr, mw, m2r, rd, rw, sa, sb, ac, done};
  endfunction

  task automatic model_step(input logic [5:0] o, input logic rdy);
    ph_t p = q[0];
    case (p)
      P_FETCH, P_RD, P_WR:
        if (rdy) begin waits = 0; void'(q.pop_front()); end
        else begin
          waits++;
          if (waits == 15) begin m_to = 1; q = {P_ERR}; waits = 0; end
        end
      P_DEC: begin
        void'(q.pop_front());
        case (o)
          6'b000000: q = {P_EXR, P_WBR};
          6'b100011: q = {P_ADDR, P_RD, P_WBM};
          6'b101011: q = {P_ADDR, P_WR};
          6'b000100: q = {P_BR};
          6'b001111: q = {P_EXL, P_WBL};
          default: begin m_ill = 1; q = {P_ERR}; end
        endcase
      end
      P_ERR: ;
      default: void'(q.pop_front());
    endcase
    if (q.size() == 0) q = {P_FETCH, P_DEC};
  endtask

  task automatic cycle(input logic [5:0] o, input logic rdy);
    ph_t p;
    @(negedge clk);
    op = o; mem_ready = rdy;
    #1;
    p = q[0];
    chk($sformatf("ctrl@%s", p.name()), 32'(obs_ctrl), 32'(exp_ctrl(p, rdy)));
    chk("illegal_op", 32'(illegal_op), 32'(m_ill));
    chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
    model_step(o, rdy);
  endtask

  // Reset takes effect mid-cycle; outputs must drop before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_ctrl", 32'(obs_ctrl), 32'd0);
    chk("rst_flags", 32'({illegal_op, mem_timeout}), 32'd0);
    q = {P_INIT}; waits = 0; m_ill = 0; m_to = 0;
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  function automatic logic [5:0] rand_op();
    int r = $urandom_range(0, 19);
    if (r < 4)  return 6'b000000;
    if (r < 8)  return 6'b100011;
    if (r < 12) return 6'b101011;
    if (r < 15) return 6'b000100;
    if (r < 18) return 6'b001111;
    if (r == 18) return 6'b111111;
    return 6'($urandom_range(0, 63));
  endfunction

  initial begin
    q = {P_INIT}; waits = 0; m_ill = 0; m_to = 0;
    // R-type, zero-wait memory
    do_reset();
    repeat (5) cycle(6'b000000, 1'b1);
    // lw with three stalls in MEM_RD
    cycle(6'b100011, 1); cycle(6'b100011, 1); cycle(6'b100011, 1);
    repeat (3) cycle(6'b100011, 0);
    cycle(6'b100011, 1); cycle(6'b100011, 1);
    // sw with one stall, then beq and lui
    cycle(6'b101011, 1); cycle(6'b101011, 1); cycle(6'b101011, 1);
    cycle(6'b101011, 0); cycle(6'b101011, 1);
    repeat (3) cycle(6'b000100, 1);
    repeat (4) cycle(6'b001111, 1);
    // illegal op, absorbing error
    cycle(6'b111111, 1); cycle(6'b111111, 1);
    repeat (20) cycle(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    do_reset();
    // fetch timeout, then ready on the last permitted cycle
    cycle(6'b0, 0);
    repeat (15) cycle(6'b0, 0);
    repeat (3) cycle(6'b0, 1);
    do_reset();
    cycle(6'b0, 0);
    repeat (14) cycle(6'b0, 0);
    cycle(6'b0, 1); cycle(6'b0, 1);
    // reset while a store is pending
    cycle(6'b101011, 1); cycle(6'b101011, 1); cycle(6'b101011, 1); cycle(6'b101011, 1);
    cycle(6'b101011, 1); cycle(6'b101011, 0); cycle(6'b101011, 0);
    do_reset();
    // random traffic with varying memory responsiveness
    for (int seg = 0; seg < 80; seg++) begin
      int pct;
      case ($urandom_range(0, 4))
        0: pct = 100;
        1: pct = 75;
        2: pct = 40;
        3: pct = 10;
        default: pct = 0;
      endcase
      if (q[0] == P_ERR || $urandom_range(0, 3) == 0) do_reset();
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 99) == 0) do_reset();
        cycle(rand_op(), 1'($urandom_range(0, 99) < pct));
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
